serial_adder_controller: RTL

//  Bit-serial WIDTH-bit adder. One full_adder cell is time-shared across all bit positions.
//  The block sequences that cell: it captures operands on a valid/ready handshake, feeds one
//  bit pair per cycle LSB-first, and registers the carry between cycles. The finished sum and

---
 rtl/serial_adder_controller_pkg.sv | 20 ++
 rtl/serial_adder_controller_full_adder.sv | 13 +
 rtl/serial_adder_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_adder_controller_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the legal operand-width range.
package serial_adder_controller_pkg;

  // Controller states; encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  // True when an operand width is inside the supported range.
  function automatic bit width_is_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_controller_full_adder.sv
// One-bit full adder cell, time-shared by the serial adder controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an input handshake,
// added one bit per cycle LSB-first through a single full_adder cell, and the
// result is held on a valid/ready output until the consumer takes it.
module serial_adder_controller
  import serial_adder_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("serial_adder_controller: WIDTH must be in 2..64");
  end

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q,      c_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_sh_shift;

  full_adder fa0 (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .carry_in  (c_q),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at LSB.
  assign sum_sh_shift = {fa_sum, sum_sh_q[WIDTH-1:1]};

  // Next-state, datapath update and handshake decisions for the controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          c_d      = carry_in;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = sum_sh_shift;
        c_d      = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_shift;
          cout_d  = fa_carry;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
